// File: rtl/md_ctrl.sv
// Sequencing controller between the X stage and the multdiv unit: issues MULT/DIV,
// stalls until completion, then presents a writeback. Optional BUSY timeout: MD_TIMEOUT_EN.
module md_ctrl #(
  parameter int RSTATUS_REG    = 30,
  parameter int MULT_EXC_CODE  = 4,
  parameter int DIV_EXC_CODE   = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic        x_is_mult,
  input  logic        x_is_div,
  input  logic [31:0] x_opA,
  input  logic [31:0] x_opB,
  input  logic [4:0]  x_rd,
  output logic        stall,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_grant,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  RSTATUS_L   = 5'(RSTATUS_REG);
  localparam logic [31:0] MULT_CODE_L = 32'(MULT_EXC_CODE);
  localparam logic [31:0] DIV_CODE_L  = 32'(DIV_EXC_CODE);

  state_t      state_q;
  logic        kind_q;
  logic [4:0]  rd_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic        wen_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        req;
  logic        to_hit;
  logic        busy_done;
  logic        done_exit;
  logic        exc_d;
  logic        wen_d;
  logic [4:0]  dst_d;
  logic [31:0] res_d;

`ifdef MD_TIMEOUT_EN
  localparam logic [5:0] TO_LAST = 6'(TIMEOUT_CYCLES - 1);

  // Counts BUSY cycles; value k-1 during the k-th BUSY cycle.
  logic [5:0] to_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      to_cnt_q <= '0;
    end else if (state_q == S_BUSY) begin
      to_cnt_q <= to_cnt_q + 6'd1;
    end
  end

  assign to_hit = (to_cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  assign req       = x_valid & (x_is_mult | x_is_div);
  assign busy_done = md_resultRDY | to_hit;
  assign done_exit = wb_grant | ~wen_q;

  // A timeout without RDY is reported exactly like an exception of the latched kind.
  always_comb begin
    exc_d = 1'b1;
    if (md_resultRDY) begin
      exc_d = md_exception;
    end
    res_d = md_result;
    dst_d = rd_q;
    if (exc_d) begin
      res_d = kind_q ? MULT_CODE_L : DIV_CODE_L;
      dst_d = RSTATUS_L;
    end
    wen_d = exc_d | (rd_q != 5'd0);
  end

  // Writeback handshake: wb_valid/wb_rd/wb_data hold stable in DONE until a cycle
  // with wb_grant=1; the transfer happens on that cycle's rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= 1'b0;
      rd_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wen_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            opa_q       <= x_opA;
            opb_q       <= x_opB;
            rd_q        <= x_rd;
            kind_q      <= x_is_mult;
            ctrl_mult_q <= x_is_mult;
            ctrl_div_q  <= ~x_is_mult;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (busy_done) begin
            wen_q      <= wen_d;
            wb_valid_q <= wen_d;
            wb_rd_q    <= dst_d;
            wb_data_q  <= res_d;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (done_exit) begin
            wb_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall drops in the cycle the writeback completes so the instruction leaves X on that edge.
  assign stall = ~reset & (((state_q == S_IDLE) & req) |
                           (state_q == S_ISSUE) |
                           (state_q == S_BUSY) |
                           ((state_q == S_DONE) & ~done_exit));

  assign md_opA       = opa_q;
  assign md_opB       = opb_q;
  assign md_ctrl_mult = ctrl_mult_q;
  assign md_ctrl_div  = ctrl_div_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign dbg_state    = state_q;

endmodule
